// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache: refill FSM states, default
// array geometry and address-split helpers.
package cache_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 32;
    localparam int INDEX_W_DEF        = 6;
    localparam int WORDS_PER_LINE_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INVAL,
        ST_REQ,
        ST_FILL,
        ST_COMMIT,
        ST_DONE
    } refill_state_e;

    // Helpers work on a 64-bit view of the address; callers size-cast the result.
    function automatic logic [63:0] addr_offset(input logic [63:0] addr, input int offw);
        return (addr >> 2) & ((64'd1 << offw) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int offw,
                                               input int indexw);
        return (addr >> (2 + offw)) & ((64'd1 << indexw) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int offw,
                                             input int indexw);
        return addr >> (2 + offw + indexw);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// Line-refill controller: invalidates the victim line, fetches a full line from
// memory, writes it into the data array, then commits tag and valid together.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDRWIDTH    = ADDR_W_DEF,
    parameter int DATAWIDTH    = DATA_W_DEF,
    parameter int INDEXWIDTH   = INDEX_W_DEF,
    parameter int WORDSPERLINE = WORDS_PER_LINE_DEF,
    localparam int OFFW        = $clog2(WORDSPERLINE),
    localparam int TAGWIDTH    = ADDRWIDTH - INDEXWIDTH - OFFW - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_req,
    input  logic [ADDRWIDTH-1:0]  miss_addr,
    output logic                  busy,
    output logic                  refill_done,
    output logic                  mem_req,
    output logic [ADDRWIDTH-1:0]  mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATAWIDTH-1:0]  mem_rdata,
    output logic                  data_cs,
    output logic                  data_web,
    output logic [INDEXWIDTH-1:0] data_index,
    output logic [OFFW-1:0]       data_offset,
    output logic [DATAWIDTH-1:0]  data_in,
    output logic                  tag_cs,
    output logic                  tag_web,
    output logic [INDEXWIDTH-1:0] tag_index,
    output logic [TAGWIDTH-1:0]   tag_in,
    output logic                  valid_cs,
    output logic                  valid_web,
    output logic [INDEXWIDTH-1:0] valid_index,
    output logic                  valid_datain
);

    refill_state_e         state_q, state_d;
    logic [INDEXWIDTH-1:0] index_q, index_d;
    logic [TAGWIDTH-1:0]   tag_q,   tag_d;
    logic [OFFW-1:0]       cnt_q,   cnt_d;
    logic [DATAWIDTH-1:0]  data_q,  data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        // NOTE: every next-state and output gets a default first, so no path infers a latch.
        state_d      = state_q;
        index_d      = index_q;
        tag_d        = tag_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        busy         = (state_q != ST_IDLE);
        refill_done  = 1'b0;
        mem_req      = 1'b0;
        data_cs      = 1'b0;
        data_web     = 1'b1;
        data_in      = data_q;
        tag_cs       = 1'b0;
        tag_web      = 1'b1;
        valid_cs     = 1'b0;
        valid_web    = 1'b1;
        valid_datain = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (miss_req) begin
                    index_d = INDEXWIDTH'(addr_index(64'(miss_addr), OFFW, INDEXWIDTH));
                    tag_d   = TAGWIDTH'(addr_tag(64'(miss_addr), OFFW, INDEXWIDTH));
                    cnt_d   = '0;
                    state_d = ST_INVAL;
                end
            end
            // Clearing valid first keeps lookups missing while the line is half-written.
            ST_INVAL: begin
                valid_cs  = 1'b1;
                valid_web = 1'b0;
                state_d   = ST_REQ;
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rvalid) begin
                    data_cs  = 1'b1;
                    data_web = 1'b0;
                    data_in  = mem_rdata;
                    data_d   = mem_rdata;
                    cnt_d    = cnt_q + OFFW'(1);
                    if (cnt_q == OFFW'(WORDSPERLINE - 1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                tag_cs       = 1'b1;
                tag_web      = 1'b0;
                valid_cs     = 1'b1;
                valid_web    = 1'b0;
                valid_datain = 1'b1;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                refill_done = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr    = {tag_q, index_q, {(OFFW + 2){1'b0}}};
    assign data_index  = index_q;
    assign tag_index   = index_q;
    assign valid_index = index_q;
    assign data_offset = cnt_q;
    assign tag_in      = tag_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed scoreboard bench for cache_refill_ctrl: expected array writes are
// queued as stimulus is driven and matched against a negedge monitor.
module tb_cache_refill_ctrl;
    import cache_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 6;
    localparam int WPL  = 4;
    localparam int OFFW = 2;
    localparam int TW   = AW - IW - OFFW - 2;

    logic          clk;
    logic          rst;
    logic          miss_req;
    logic [AW-1:0] miss_addr;
    logic          busy, refill_done, mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          data_cs, data_web;
    logic [IW-1:0] data_index;
    logic [OFFW-1:0] data_offset;
    logic [DW-1:0] data_in;
    logic          tag_cs, tag_web;
    logic [IW-1:0] tag_index;
    logic [TW-1:0] tag_in;
    logic          valid_cs, valid_web;
    logic [IW-1:0] valid_index;
    logic          valid_datain;

    cache_refill_ctrl #(
        .ADDRWIDTH   (AW),
        .DATAWIDTH   (DW),
        .INDEXWIDTH  (IW),
        .WORDSPERLINE(WPL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_req    (miss_req),
        .miss_addr   (miss_addr),
        .busy        (busy),
        .refill_done (refill_done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .data_cs     (data_cs),
        .data_web    (data_web),
        .data_index  (data_index),
        .data_offset (data_offset),
        .data_in     (data_in),
        .tag_cs      (tag_cs),
        .tag_web     (tag_web),
        .tag_index   (tag_index),
        .tag_in      (tag_in),
        .valid_cs    (valid_cs),
        .valid_web   (valid_web),
        .valid_index (valid_index),
        .valid_datain(valid_datain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_NONE, EV_INVAL, EV_DATA, EV_COMMIT, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int          cyc;
        logic [31:0] index;
        logic [31:0] offset;
        logic [31:0] data;
        logic [31:0] tag;
    } ev_t;

    ev_t exp_q[$];
    int  n_asserts     = 0;
    int  n_fail        = 0;
    int  last_done_cyc = -1;
    int  last_inval_cyc = -1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic push(input ev_kind_e k, input int c, input logic [31:0] idx,
                        input logic [31:0] off, input logic [31:0] dat, input logic [31:0] tg);
        ev_t e;
        e.kind = k; e.cyc = c; e.index = idx; e.offset = off; e.data = dat; e.tag = tg;
        exp_q.push_back(e);
    endtask

    task automatic match(input ev_kind_e k, input logic [31:0] idx, input logic [31:0] off,
                         input logic [31:0] dat, input logic [31:0] tg);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_array_event", 64'(k), 64'(EV_NONE));
            return;
        end
        e = exp_q.pop_front();
        check("ev_kind", 64'(k), 64'(e.kind));
        check("ev_cycle", 64'(cyc), 64'(e.cyc));
        if (k != EV_DONE) check("ev_index", 64'(idx), 64'(e.index));
        if (k == EV_DATA) begin
            check("ev_offset", 64'(off), 64'(e.offset));
            check("ev_data", 64'(dat), 64'(e.data));
        end
        if (k == EV_COMMIT) check("ev_tag", 64'(tg), 64'(e.tag));
    endtask

    // Monitor: samples on the falling edge, away from input changes and clock edges.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_cs && !valid_web && !tag_cs) begin
                check("inval_datain", 64'(valid_datain), 64'(0));
                last_inval_cyc = cyc;
                match(EV_INVAL, 32'(valid_index), 32'(0), 32'(0), 32'(0));
            end
            if (tag_cs && !tag_web) begin
                check("commit_valid_write", 64'({valid_cs, valid_web, valid_datain}), 64'(3'b101));
                check("commit_index_pair", 64'(tag_index), 64'(valid_index));
                match(EV_COMMIT, 32'(tag_index), 32'(0), 32'(0), 32'(tag_in));
            end
            if (data_cs && !data_web) begin
                match(EV_DATA, 32'(data_index), 32'(data_offset), data_in, 32'(0));
            end
            if (refill_done) begin
                last_done_cyc = cyc;
                match(EV_DONE, 32'(0), 32'(0), 32'(0), 32'(0));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one refill starting in an IDLE cycle; returns in the DONE cycle
    // (or two cycles after an aborting reset). Gap bit w inserts one idle FILL
    // cycle before word w.
    task automatic do_refill(input logic [31:0] addr, input logic [31:0] dbase,
                             input int gnt_delay, input logic [3:0] gap_mask,
                             input bit spurious, input bit miss_in_fill,
                             input bit hold, input logic [31:0] next_addr,
                             input int abort_after, output int start_cyc);
        logic [31:0] idx, tg, base;
        idx  = (addr >> 4) & 32'h3F;
        tg   = addr >> 10;
        base = addr & ~32'hF;

        miss_req  = 1'b1;
        miss_addr = addr;
        start_cyc = cyc;
        check("idle_busy", 64'(busy), 64'(0));

        next_cycle();
        miss_req = hold;
        if (hold) miss_addr = next_addr;
        mem_rvalid = spurious;
        mem_rdata  = 32'hDEAD_BEEF;
        push(EV_INVAL, cyc, idx, 0, 0, 0);
        check("inval_busy", 64'(busy), 64'(1));
        check("inval_mem_req", 64'(mem_req), 64'(0));

        for (int d = 0; d <= gnt_delay; d++) begin
            next_cycle();
            miss_req   = hold;
            mem_gnt    = (d == gnt_delay);
            mem_rvalid = spurious;
            check("req_mem_req", 64'(mem_req), 64'(1));
            check("req_mem_addr", 64'(mem_addr), 64'(base));
        end

        for (int w = 0; w < WPL; w++) begin
            if (gap_mask[w]) begin
                next_cycle();
                miss_req   = hold;
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hBAD0_0000;
                check("gap_mem_req", 64'(mem_req), 64'(0));
            end
            next_cycle();
            miss_req   = hold | (miss_in_fill && w == 1);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = dbase + 32'(w);
            push(EV_DATA, cyc, idx, 32'(w), dbase + 32'(w), 0);
            if (abort_after == w) begin
                next_cycle();
                miss_req   = 1'b0;
                mem_rvalid = 1'b0;
                rst        = 1'b0;
                #1;
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_mem_req", 64'(mem_req), 64'(0));
                check("abort_mem_addr", 64'(mem_addr), 64'(0));
                next_cycle();
                check("abort_idle_busy", 64'(busy), 64'(0));
                rst = 1'b1;
                return;
            end
        end

        next_cycle();
        miss_req   = hold;
        mem_rvalid = 1'b0;
        push(EV_COMMIT, cyc, idx, 0, 0, tg);
        check("commit_busy", 64'(busy), 64'(1));

        next_cycle();
        miss_req = hold;
        push(EV_DONE, cyc, 0, 0, 0, 0);
        check("done_mem_req", 64'(mem_req), 64'(0));
    endtask

    int s, dur_best, dur_stall, d1;
    logic [31:0] addr_a, addr_b;

    initial begin
        rst        = 1'b0;
        miss_req   = 1'b0;
        miss_addr  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        repeat (3) next_cycle();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(refill_done), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_cs", 64'({data_cs, tag_cs, valid_cs}), 64'(0));
        check("rst_web", 64'({data_web, tag_web, valid_web}), 64'(3'b111));
        check("rst_idx", 64'({data_index, tag_index, valid_index, data_offset}), 64'(0));
        check("rst_data_tag", 64'({data_in, tag_in, valid_datain}), 64'(0));

        rst = 1'b1;
        repeat (10) next_cycle();
        check("idle_busy10", 64'(busy), 64'(0));
        check("idle_web10", 64'({data_web, tag_web, valid_web}), 64'(3'b111));
        check("idle_cs10", 64'({data_cs, tag_cs, valid_cs}), 64'(0));
        check("idle_mem_req10", 64'(mem_req), 64'(0));

        // Best case: index 0x23, tag 0x1234>>10 = 0x4, done 8 cycles after the miss.
        do_refill(32'h0000_1234, 32'hA0, 0, 4'b0000, 0, 0, 0, 0, -1, s);
        dur_best = cyc - s;
        check("best_latency", 64'(dur_best), 64'(8));
        next_cycle();
        check("post_best_busy", 64'(busy), 64'(0));
        check("post_best_data_hold", 64'(data_in), 64'(32'hA3));
        check("post_best_tag_hold", 64'(tag_in), 64'(4));
        check("post_best_addr_hold", 64'(mem_addr), 64'(32'h0000_1230));

        // Stalls: grant delayed 3 cycles, gaps after words 1 and 2.
        do_refill(32'h0000_5678, 32'hB0, 3, 4'b1100, 0, 0, 0, 0, -1, s);
        dur_stall = cyc - s;
        check("stall_extra_cycles", 64'(dur_stall - dur_best), 64'(5));
        next_cycle();

        // Spurious rvalid in INVAL/REQ and a miss pulse during FILL.
        do_refill(32'hABCD_0040, 32'hC0, 1, 4'b0000, 1, 1, 0, 0, -1, s);
        repeat (4) begin
            next_cycle();
            check("second_miss_ignored", 64'(busy), 64'(0));
        end

        // Reset after word 2, then a clean refill with counter restarting at 0.
        do_refill(32'h0000_2220, 32'hD0, 0, 4'b0000, 0, 0, 0, 0, 2, s);
        next_cycle();
        check("abort_no_pending", 64'(exp_q.size()), 64'(0));
        do_refill(32'h0000_3330, 32'hE0, 0, 4'b0010, 0, 0, 0, 0, -1, s);
        next_cycle();

        // Back-to-back: miss_req held high; DONE, one IDLE cycle, then INVAL.
        addr_a = (32'h11 << 10) | (32'd3 << 4);
        addr_b = (32'h22 << 10) | (32'd4 << 4);
        do_refill(addr_a, 32'hF0, 0, 4'b0000, 0, 0, 1, addr_b, -1, s);
        next_cycle();
        d1 = last_done_cyc;
        do_refill(addr_b, 32'hF8, 0, 4'b0000, 0, 0, 0, 0, -1, s);
        check("b2b_inval_after_done", 64'(last_inval_cyc - d1), 64'(2));
        next_cycle();

        repeat (3) next_cycle();
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
